move_checker: RTL and testbench

MOVE_CHECKER -- requirements
Module: move_checker

---
 rtl/chess_pkg.sv | 43 ++++
 rtl/move_checker_if.sv | 13 +
 rtl/piece_geometry.sv | 76 +++++++
 rtl/move_checker.sv | 123 ++++++++++++
 tb/tb_move_checker.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings for the move checker: piece codes, square geometry widths,
// FSM states and small board-access helpers.
package chess_pkg;

  localparam int SQ_W      = 6;
  localparam int ROW_W     = 3;
  localparam int COL_W     = 3;
  localparam int SLICE_W   = 4;
  localparam int COLOR_BIT = 3;
  localparam int BOARD_W   = 64 * SLICE_W;

  typedef enum logic [2:0] {
    P_EMPTY  = 3'd0,
    P_PAWN   = 3'd1,
    P_KNIGHT = 3'd2,
    P_BISHOP = 3'd3,
    P_ROOK   = 3'd4,
    P_QUEEN  = 3'd5,
    P_KING   = 3'd6,
    P_BAD    = 3'd7
  } piece_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WALK   = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic [SLICE_W-1:0] square_at(input logic [BOARD_W-1:0] b,
                                                   input logic [SQ_W-1:0]    sq);
    return b[{sq, 2'b00} +: SLICE_W];
  endfunction

  function automatic logic is_empty(input logic [SLICE_W-1:0] p);
    return piece_e'(p[2:0]) == P_EMPTY;
  endfunction

  function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/move_checker_if.sv
// Request/response bundle of the move checker, as seen by a requester (master)
// and by the checker (slave).
interface move_checker_if;
  logic         start;
  logic [255:0] board;
  logic [12:0]  move_data;
  logic         busy;
  logic         done;
  logic         allow_move;

  modport master (output start, board, move_data, input busy, done, allow_move);
  modport slave  (input start, board, move_data, output busy, done, allow_move);
endinterface

// File: rtl/piece_geometry.sv
// Pure row/column geometry for one piece moving from one square to another:
// shape legality, whether the piece slides, the per-square step and the path length.
module piece_geometry
  import chess_pkg::*;
(
  input  logic [SLICE_W-1:0] piece,
  input  logic [SQ_W-1:0]    from,
  input  logic [SQ_W-1:0]    to,
  output logic               geometry_ok,
  output logic               sliding,
  output logic               capture_only,
  output logic [SQ_W-1:0]    step,
  output logic [2:0]         n_mid
);
  logic [ROW_W-1:0] fr, tr;
  logic [COL_W-1:0] fc, tc;
  logic [2:0]       adr, adc, span;
  logic             white, ahead, pawn_row;
  logic             push1, push2, diag_step;
  logic [SQ_W-1:0]  row_step, col_step;
  piece_e           kind;

  assign fr   = from[5:3];
  assign fc   = from[2:0];
  assign tr   = to[5:3];
  assign tc   = to[2:0];
  assign adr  = abs_diff(fr, tr);
  assign adc  = abs_diff(fc, tc);
  assign span = (adr > adc) ? adr : adc;
  assign kind = piece_e'(piece[2:0]);

  assign white    = ~piece[COLOR_BIT];
  assign ahead    = white ? (tr > fr) : (tr < fr);
  assign pawn_row = white ? (fr == 3'd1) : (fr == 3'd6);

  assign push1     = (adc == 3'd0) && ahead && (adr == 3'd1);
  assign push2     = (adc == 3'd0) && ahead && (adr == 3'd2) && pawn_row;
  assign diag_step = (adc == 3'd1) && ahead && (adr == 3'd1);

  // Offsets are two's complement mod 64 so the walker can simply add them.
  assign row_step = (tr > fr) ? 6'd8 : (tr < fr) ? 6'd56 : 6'd0;
  assign col_step = (tc > fc) ? 6'd1 : (tc < fc) ? 6'd63 : 6'd0;
  assign step     = row_step + col_step;

  always_comb begin
    // NOTE: every output gets a default first so no branch can infer a latch.
    geometry_ok  = 1'b0;
    sliding      = 1'b0;
    capture_only = 1'b0;
    n_mid        = 3'd0;
    case (kind)
      P_PAWN: begin
        geometry_ok  = push1 | push2 | diag_step;
        capture_only = diag_step;
        n_mid        = push2 ? 3'd1 : 3'd0;
      end
      P_KNIGHT: geometry_ok = ((adr == 3'd1) && (adc == 3'd2)) || ((adr == 3'd2) && (adc == 3'd1));
      P_BISHOP: begin
        geometry_ok = (adr == adc);
        sliding     = 1'b1;
      end
      P_ROOK: begin
        geometry_ok = (adr == 3'd0) || (adc == 3'd0);
        sliding     = 1'b1;
      end
      P_QUEEN: begin
        geometry_ok = (adr == 3'd0) || (adc == 3'd0) || (adr == adc);
        sliding     = 1'b1;
      end
      P_KING:  geometry_ok = (span == 3'd1);
      default: geometry_ok = 1'b0;
    endcase
    if (sliding && span != 3'd0) n_mid = span - 3'd1;
  end

endmodule

// File: rtl/move_checker.sv
// Chess move legality checker: decodes a latched move, walks sliding paths one square per cycle.
// Build option MOVE_CHECKER_TURN_EN: require the moved piece's colour to match moveData[12].
module move_checker
  import chess_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] board,
  input  logic [12:0]  moveData,
  output logic         busy,
  output logic         done,
  output logic         allowMove
);
  state_e          state, next_state;
  logic [255:0]    board_q;
  logic [12:0]     move_q;
  logic [SQ_W-1:0] from_sq, to_sq, mid_sq, pos;
  logic [2:0]      remaining;
  logic [3:0]      from_pc, to_pc, mid_pc, pos_pc;
  piece_e          from_kind;
  logic            geometry_ok, sliding, capture_only;
  logic [SQ_W-1:0] step;
  logic [2:0]      n_mid;
  logic            to_empty, to_own, turn_ok, reject, pawn_ok, result_d, allow_q;

  assign from_sq   = move_q[11:6];
  assign to_sq     = move_q[5:0];
  assign from_pc   = square_at(board_q, from_sq);
  assign to_pc     = square_at(board_q, to_sq);
  assign mid_sq    = from_sq + step;
  assign mid_pc    = square_at(board_q, mid_sq);
  assign pos_pc    = square_at(board_q, pos);
  assign from_kind = piece_e'(from_pc[2:0]);

  piece_geometry u_geometry (
    .piece        (from_pc),
    .from         (from_sq),
    .to           (to_sq),
    .geometry_ok  (geometry_ok),
    .sliding      (sliding),
    .capture_only (capture_only),
    .step         (step),
    .n_mid        (n_mid)
  );

`ifdef MOVE_CHECKER_TURN_EN
  assign turn_ok = (from_pc[COLOR_BIT] == move_q[12]);
`else
  logic unused_turn;
  assign unused_turn = move_q[12];
  assign turn_ok     = 1'b1;
`endif

  assign to_empty = is_empty(to_pc);
  assign to_own   = !to_empty && (to_pc[COLOR_BIT] == from_pc[COLOR_BIT]);
  assign reject   = (from_sq == to_sq) || (from_kind == P_EMPTY) || (from_kind == P_BAD) ||
                    to_own || !geometry_ok || !turn_ok;
  // A double push reports one intermediate square: the one that must also be empty.
  assign pawn_ok  = capture_only ? !to_empty
                                 : (to_empty && ((n_mid == 3'd0) || is_empty(mid_pc)));

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: registers use non-blocking assignments so each samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    result_d   = 1'b0;
    case (state)
      IDLE: if (start) next_state = DECODE;
      DECODE: begin
        next_state = DONE;
        if (reject)                          result_d = 1'b0;
        else if (from_kind == P_PAWN)        result_d = pawn_ok;
        else if (sliding && n_mid != 3'd0)   next_state = WALK;
        else                                 result_d = 1'b1;
      end
      WALK: begin
        if (!is_empty(pos_pc)) begin
          next_state = DONE;
        end else if (remaining == 3'd1) begin
          next_state = DONE;
          result_d   = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the wide board latch is reset too; a cleared copy after reset is required behaviour.
    if (!reset) begin
      board_q   <= '0;
      move_q    <= '0;
      pos       <= '0;
      remaining <= '0;
      allow_q   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        board_q <= board;
        move_q  <= moveData;
        allow_q <= 1'b0;
      end
      if (state == DECODE) begin
        pos       <= mid_sq;
        remaining <= n_mid;
      end else if (state == WALK) begin
        pos       <= pos + step;
        remaining <= remaining - 3'd1;
      end
      if (next_state == DONE) allow_q <= result_d;
    end
  end

  assign busy      = (state == DECODE) || (state == WALK);
  assign done      = (state == DONE);
  assign allowMove = allow_q;

endmodule

// File: tb/tb_move_checker.sv
// Scoreboard bench for move_checker: directed board scenarios plus random moves
// checked against a square-by-square reference model of the chess rules.
module tb_move_checker;

  typedef struct {
    bit ok;
    int due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  move_checker_if bus ();

  move_checker dut (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .board     (bus.board),
    .moveData  (bus.move_data),
    .busy      (bus.busy),
    .done      (bus.done),
    .allowMove (bus.allow_move)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("allow_move", bus.allow_move, mon_e.ok);
        check("done_latency", cyc, mon_e.due);
      end
    end
  end

  // Reference rules evaluated directly on rows, columns and the square path.
  function automatic void model(input logic [255:0] b, input logic [12:0] m,
                                output bit ok, output int lat);
    int f, t, dr, dc, adr, adc, n, sr, sc, dir, kind, col, tkind, tcol;
    bit straight, diag;
    f     = m[11:6];
    t     = m[5:0];
    dr    = t / 8 - f / 8;
    dc    = t % 8 - f % 8;
    adr   = (dr < 0) ? -dr : dr;
    adc   = (dc < 0) ? -dc : dc;
    kind  = b[f*4 +: 3];
    col   = b[f*4 + 3];
    tkind = b[t*4 +: 3];
    tcol  = b[t*4 + 3];
    ok    = 1'b0;
    lat   = 2;
    if (f == t || kind == 0 || kind == 7) return;
    if (tkind != 0 && tcol == col) return;
`ifdef MOVE_CHECKER_TURN_EN
    if (col != int'(m[12])) return;
`endif
    straight = (dr == 0) || (dc == 0);
    diag     = (adr == adc);
    case (kind)
      1: begin
        dir = (col != 0) ? -1 : 1;
        if (dc == 0 && dr == dir) ok = (tkind == 0);
        else if (dc == 0 && dr == 2 * dir && f / 8 == ((col != 0) ? 6 : 1))
          ok = (tkind == 0) && (b[(f + 8 * dir)*4 +: 3] == 3'd0);
        else if (adc == 1 && dr == dir) ok = (tkind != 0);
      end
      2: ok = (adr * adc == 2);
      6: ok = (adr <= 1) && (adc <= 1);
      default: begin
        if (kind == 3 && !diag) return;
        if (kind == 4 && !straight) return;
        if (kind == 5 && !(diag || straight)) return;
        sr = (dr > 0) ? 1 : (dr < 0) ? -1 : 0;
        sc = (dc > 0) ? 1 : (dc < 0) ? -1 : 0;
        n  = (adr > adc) ? adr : adc;
        for (int i = 1; i < n; i++) begin
          lat = 2 + i;
          if (b[((f / 8 + i * sr) * 8 + f % 8 + i * sc)*4 +: 3] != 3'd0) return;
        end
        ok = 1'b1;
      end
    endcase
  endfunction

  // Issue one request, queue its expectation, and wait (bounded) for the monitor to retire it.
  task automatic run_move(input logic [255:0] b, input logic [12:0] m,
                          input bit ok, input int lat, input int inject);
    exp_t e;
    bit   seen;
    @(negedge clk);
    bus.board     = b;
    bus.move_data = m;
    bus.start     = 1'b1;
    e.ok  = ok;
    e.due = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        seen = 1'b1;
      end else if (inject != 0 && i == inject) begin
        bus.start     = 1'b1;
        bus.board     = '0;
        bus.move_data = ~m;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [255:0] bd;
    logic [12:0]  mv;
    bit           ok;
    int           lat, f, t, fr, fc, dr, dc, k;

    bus.start     = 1'b0;
    bus.board     = '0;
    bus.move_data = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_allow", bus.allow_move, 0);
    reset = 1'b1;

    // Rook a1->a8 on an empty file, then the same with a start pulse mid-walk.
    bd = '0;
    bd[0 +: 4] = 4'h4;
    run_move(bd, {1'b0, 6'd0, 6'd56}, 1'b1, 8, 0);
    run_move(bd, {1'b0, 6'd0, 6'd56}, 1'b1, 8, 1);
    bd[24*4 +: 4] = 4'h9;
    run_move(bd, {1'b0, 6'd0, 6'd56}, 1'b0, 5, 0);

    bd = '0;
    bd[1*4 +: 4] = 4'h2;
    run_move(bd, {1'b0, 6'd1, 6'd18}, 1'b1, 2, 0);
    run_move(bd, {1'b0, 6'd1, 6'd17}, 1'b0, 2, 0);

    bd = '0;
    bd[12*4 +: 4] = 4'h1;
    run_move(bd, {1'b0, 6'd12, 6'd28}, 1'b1, 2, 0);
    run_move(bd, {1'b0, 6'd12, 6'd21}, 1'b0, 2, 0);
    bd[21*4 +: 4] = 4'hA;
    run_move(bd, {1'b0, 6'd12, 6'd21}, 1'b1, 2, 0);
    bd[20*4 +: 4] = 4'h9;
    run_move(bd, {1'b0, 6'd12, 6'd28}, 1'b0, 2, 0);

    bd = '0;
    bd[7*4 +: 4] = 4'h3;
    bd[4*4 +: 4] = 4'h6;
    run_move(bd, {1'b0, 6'd7, 6'd8}, 1'b0, 2, 0);
    run_move(bd, {1'b0, 6'd4, 6'd6}, 1'b0, 2, 0);
    run_move(bd, {1'b0, 6'd4, 6'd13}, 1'b1, 2, 0);

    bd = '0;
    bd[0 +: 4] = 4'h4;
`ifdef MOVE_CHECKER_TURN_EN
    run_move(bd, {1'b1, 6'd0, 6'd8}, 1'b0, 2, 0);
`else
    run_move(bd, {1'b1, 6'd0, 6'd8}, 1'b1, 2, 0);
`endif

    // Reset in the middle of a walk: no done pulse, outputs cleared, then normal service.
    @(negedge clk);
    bus.board     = bd;
    bus.move_data = {1'b0, 6'd0, 6'd56};
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midwalk_reset_busy", bus.busy, 0);
    check("midwalk_reset_done", bus.done, 0);
    check("midwalk_reset_allow", bus.allow_move, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    bd = '0;
    bd[1*4 +: 4] = 4'h2;
    run_move(bd, {1'b0, 6'd1, 6'd18}, 1'b1, 2, 0);

    for (int n = 0; n < 150; n++) begin
      bd = '0;
      for (int s = 0; s < 64; s++)
        if ($urandom_range(0, 4) == 0) bd[s*4 +: 4] = 4'($urandom_range(1, 15));
      f  = int'($urandom_range(0, 63));
      fr = f / 8;
      fc = f % 8;
      bd[f*4 +: 4] = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 4))
        0: t = int'($urandom_range(0, 63));
        1: t = fr * 8 + int'($urandom_range(0, 7));
        2: t = int'($urandom_range(0, 7)) * 8 + fc;
        3: begin
          k  = int'($urandom_range(1, 7));
          dr = ($urandom_range(0, 1) != 0) ? k : -k;
          dc = ($urandom_range(0, 1) != 0) ? k : -k;
          t  = (fr + dr >= 0 && fr + dr < 8 && fc + dc >= 0 && fc + dc < 8)
               ? (fr + dr) * 8 + fc + dc : int'($urandom_range(0, 63));
        end
        default: begin
          dr = int'($urandom_range(0, 4)) - 2;
          dc = int'($urandom_range(0, 4)) - 2;
          t  = (fr + dr >= 0 && fr + dr < 8 && fc + dc >= 0 && fc + dc < 8)
               ? (fr + dr) * 8 + fc + dc : int'($urandom_range(0, 63));
        end
      endcase
      mv = {1'($urandom_range(0, 1)), 6'(f), 6'(t)};
      model(bd, mv, ok, lat);
      run_move(bd, mv, ok, lat, 0);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
